// File: rtl/spi_master_ctrl_if.sv
// Parallel request/response side of the SPI master: one request in, one
// completion pulse (with read data) out.
interface spi_master_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (
    output start, rw, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  start, rw, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: turns one {addr, rw, wdata} request into a 16-bit frame
// on sclk/cs/mosi and returns the 8 miso bits of a read in parallel.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  spi_master_ctrl_if.slave   bus,
  output logic               sclk,
  output logic               cs,
  output logic               mosi,
  input  logic               miso
);

  localparam int FRAME_W = ADDR_W + 1 + DATA_W;
  localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(FRAME_W - 1);
  localparam logic [4:0] RX_FIRST = 5'(ADDR_W + 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   div_cnt;
  logic               tick;
  logic [4:0]         bit_cnt;
  logic [FRAME_W-2:0] pend;
  logic [DATA_W-1:0]  rx;
  logic               rw_q;
  logic               phase;

  always_comb begin
    tick = (div_cnt == CNT_LAST);
  end

  // mosi is its own register; pend holds only the bits still to be sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      pend      <= '0;
      rx        <= '0;
      rw_q      <= 1'b0;
      phase     <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.rdata <= '0;
      sclk      <= 1'b0;
      cs        <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;

      case (state)
        IDLE: begin
          sclk <= 1'b0;
          cs   <= 1'b1;
          if (bus.start) begin
            pend     <= {bus.addr[ADDR_W-2:0], bus.rw,
                         bus.rw ? {DATA_W{1'b0}} : bus.wdata};
            mosi     <= bus.addr[ADDR_W-1];
            rw_q     <= bus.rw;
            rx       <= '0;
            bit_cnt  <= '0;
            phase    <= 1'b0;
            bus.busy <= 1'b1;
            cs       <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            if (rw_q && bit_cnt >= RX_FIRST) rx <= {rx[DATA_W-2:0], miso};
            sclk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              mosi  <= 1'b0;
              phase <= 1'b0;
              state <= HOLD;
            end else begin
              mosi    <= pend[FRAME_W-2];
              pend    <= {pend[FRAME_W-3:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
              state   <= LOW;
            end
          end
        end
        // HOLD spans the trailing sclk-low half-period plus the cs hold
        // half-period, giving 36 half-periods per frame in total.
        HOLD: begin
          if (tick) begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              cs    <= 1'b1;
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              phase    <= 1'b0;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              if (rw_q) bus.rdata <= rx;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: CLK_DIV=4 and CLK_DIV=1 instances,
// a miso slave model and a done-driven monitor that checks each frame.
module tb_spi_master_ctrl;

  typedef struct {
    int          inst;
    logic [15:0] frame;
    logic [7:0]  rdata;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_master_ctrl_if if0();
  spi_master_ctrl_if if1();

  logic sclk_v[2], cs_v[2], mosi_v[2], miso_v[2];
  logic busy_v[2], done_v[2];
  logic [7:0] rdata_v[2];

  assign busy_v[0]  = if0.busy;
  assign busy_v[1]  = if1.busy;
  assign done_v[0]  = if0.done;
  assign done_v[1]  = if1.done;
  assign rdata_v[0] = if0.rdata;
  assign rdata_v[1] = if1.rdata;

  spi_master_ctrl #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .bus(if0),
    .sclk(sclk_v[0]), .cs(cs_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0])
  );

  spi_master_ctrl #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1),
    .sclk(sclk_v[1]), .cs(cs_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1])
  );

  int chk = 0;
  int err = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int          rises[2], falls[2], busy_cnt[2];
  logic [15:0] cap[2];
  logic        prev_sclk[2];
  logic [7:0]  slave_byte[2];
  exp_t        e_m;

  initial begin
    for (int i = 0; i < 2; i++) begin
      miso_v[i] = 1'b0;
      slave_byte[i] = 8'h00;
    end
  end

  // Slave model drives the next miso bit after each sclk fall; bits outside
  // the data phase are random noise that must never reach rdata.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        rises[i] = 0; falls[i] = 0; busy_cnt[i] = 0;
        cap[i] = '0; prev_sclk[i] = 1'b0; miso_v[i] = 1'b0;
      end else begin
        if (busy_v[i]) busy_cnt[i]++;
        if (sclk_v[i] && !prev_sclk[i]) begin
          cap[i] = {cap[i][14:0], mosi_v[i]};
          rises[i]++;
        end
        if (!sclk_v[i] && prev_sclk[i]) falls[i]++;
        prev_sclk[i] = sclk_v[i];
        if (falls[i] >= 8 && falls[i] <= 15) miso_v[i] = slave_byte[i][15 - falls[i]];
        else miso_v[i] = 1'($urandom_range(0, 1));
        if (done_v[i]) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e_m = sb.pop_front();
            check("done_instance", i, e_m.inst);
            check("mosi_frame", {16'h0, cap[i]}, {16'h0, e_m.frame});
            check("rdata", {24'h0, rdata_v[i]}, {24'h0, e_m.rdata});
            check("sclk_rises", rises[i], 16);
            check("busy_cycles", busy_cnt[i], e_m.len);
          end
          rises[i] = 0; falls[i] = 0; busy_cnt[i] = 0; cap[i] = '0;
        end
      end
    end
  end

  task automatic set_req(input int inst, input logic s, input logic r,
                         input logic [6:0] a, input logic [7:0] d);
    if (inst == 0) begin
      if0.start = s; if0.rw = r; if0.addr = a; if0.wdata = d;
    end else begin
      if1.start = s; if1.rw = r; if1.addr = a; if1.wdata = d;
    end
  endtask

  task automatic issue(input int inst, input logic r, input logic [6:0] a,
                       input logic [7:0] d, input logic push, input logic [7:0] exp_rd);
    exp_t e;
    @(negedge clk);
    set_req(inst, 1'b1, r, a, d);
    if (push) begin
      e.inst  = inst;
      e.frame = {a, r, r ? 8'h00 : d};
      e.rdata = exp_rd;
      e.len   = 36 * ((inst == 0) ? 4 : 1);
      sb.push_back(e);
    end
    @(negedge clk);
    set_req(inst, 1'b0, ~r, ~a, ~d);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      check("drain_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    int tog, n, run;
    logic p;
    set_req(0, 1'b0, 1'b0, 7'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 7'h00, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cs", cs_v[0], 1);
    check("rst_sclk", sclk_v[0], 0);
    check("rst_mosi", mosi_v[0], 0);
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_rdata", rdata_v[0], 0);
    tog = 0;
    p = sclk_v[0];
    repeat (50) begin
      @(negedge clk);
      if (sclk_v[0] !== p) tog++;
      p = sclk_v[0];
    end
    check("idle_sclk_toggles", tog, 0);

    slave_byte[0] = 8'hFF;
    issue(0, 1'b0, 7'h2A, 8'hC3, 1'b1, 8'h00);
    drain(400);

    slave_byte[0] = 8'hA5;
    issue(0, 1'b1, 7'h05, 8'h77, 1'b1, 8'hA5);
    drain(400);

    // Back-to-back: start held high across the first done.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 7'h11, 8'h5A);
    for (int k = 0; k < 2; k++) sb.push_back('{0, {7'h11, 1'b0, 8'h5A}, 8'hA5, 144});
    n = 0; run = 0;
    while (!done_v[0] && n < 400) begin
      @(negedge clk);
      if (cs_v[0]) run++; else run = 0;
      n++;
    end
    check("b2b_first_done_seen", n < 400, 1);
    check("b2b_gap_cs_high", (run >= 8 && run <= 9), 1);
    @(negedge clk);
    check("b2b_restart_busy", busy_v[0], 1);
    check("b2b_restart_cs", cs_v[0], 0);
    if0.start = 1'b0;
    repeat (3) begin
      repeat (20) @(negedge clk);
      set_req(0, 1'b1, 1'b1, 7'h7F, 8'h00);
      @(negedge clk);
      if0.start = 1'b0;
    end
    drain(400);
    repeat (200) @(negedge clk);
    check("no_extra_frames_busy", busy_v[0], 0);
    check("no_extra_frames_queue", sb.size(), 0);

    // Reset after the 10th rising edge of an unscored frame.
    issue(0, 1'b0, 7'h6B, 8'hE1, 1'b0, 8'h00);
    n = 0;
    while (rises[0] < 10 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_edge10", rises[0], 10);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cs", cs_v[0], 1);
    check("midrst_sclk", sclk_v[0], 0);
    check("midrst_busy", busy_v[0], 0);
    check("midrst_done", done_v[0], 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    slave_byte[0] = 8'h3C;
    issue(0, 1'b1, 7'h7F, 8'h00, 1'b1, 8'h3C);
    drain(400);

    slave_byte[1] = 8'h00;
    issue(1, 1'b0, 7'h55, 8'h96, 1'b1, 8'h00);
    drain(100);
    slave_byte[1] = 8'hC6;
    issue(1, 1'b1, 7'h12, 8'h00, 1'b1, 8'hC6);
    drain(100);

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
